// File: rtl/arith_pkg.sv
// Shared encodings and flag layout for the arithmetic result path.
`timescale 1ns/1ps
package arith_pkg;

    typedef enum logic [1:0] {
        ARITH_ADD = 2'b00,
        ARITH_SUB = 2'b01,
        ARITH_MUL = 2'b10,
        ARITH_DIV = 2'b11
    } arith_op_e;

    localparam int unsigned FLAGS_W = 5;

    localparam int unsigned FLG_Z = 0;
    localparam int unsigned FLG_N = 1;
    localparam int unsigned FLG_C = 2;
    localparam int unsigned FLG_V = 3;
    localparam int unsigned FLG_D = 4;

endpackage

// File: rtl/arith_skid_fifo.sv
// Generic Depth x Width valid/ready buffer; Depth must be a power of two >= 2.
`timescale 1ns/1ps
module arith_skid_fifo #(
    parameter int unsigned Width = 37,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push, pop;

    // Full blocks a push even when a pop coincides: no combinational ready path.
    assign in_ready_o  = (count_q != CntW'(Depth));
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: reads are masked to zero while empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

endmodule

// File: rtl/arith_result_stage.sv
// Registered result/flag stage after the arithmetic unit, with carry/borrow chain feedback.
// Optional sticky {D,V} accumulation is built when ARITH_STICKY_FLAGS_EN is defined.
`timescale 1ns/1ps
module arith_result_stage import arith_pkg::*; #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         sel_arith,
    input  logic [WIDTH-1:0]   result,
    input  logic [WIDTH-1:0]   multiplication_upperbits,
    input  logic [WIDTH-1:0]   remainder_left,
    input  logic               carryout,
    input  logic               borrowout,
    input  logic               signed_overflow,
    input  logic               divbyzero,
    input  logic               chain_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic [WIDTH-1:0]   out_aux,
    output logic [FLAGS_W-1:0] out_flags,
    output logic               carry_fb,
    output logic               borrow_fb,
    output logic [1:0]         sticky_flags
);

    localparam int unsigned EntryW = 2 * WIDTH + FLAGS_W;

    logic [FLAGS_W-1:0] flags_in;
    logic [WIDTH-1:0]   aux_in;
    logic [EntryW-1:0]  entry_in, entry_out;
    logic               push;
    logic               carry_fb_q, carry_fb_d;
    logic               borrow_fb_q, borrow_fb_d;

    always_comb begin
        flags_in        = '0;
        aux_in          = '0;
        flags_in[FLG_Z] = (result == '0);
        flags_in[FLG_N] = result[WIDTH-1];
        case (sel_arith)
            ARITH_ADD: begin
                flags_in[FLG_C] = carryout;
                flags_in[FLG_V] = signed_overflow;
            end
            ARITH_SUB: begin
                flags_in[FLG_C] = borrowout;
                flags_in[FLG_V] = signed_overflow;
            end
            ARITH_MUL: aux_in = multiplication_upperbits;
            ARITH_DIV: begin
                aux_in          = remainder_left;
                flags_in[FLG_D] = divbyzero;
            end
            default: ;
        endcase
    end

    assign entry_in = {result, aux_in, flags_in};
    assign push     = in_valid && in_ready;

    arith_skid_fifo #(
        .Width (EntryW),
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (entry_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (entry_out)
    );

    assign out_result = entry_out[EntryW-1 -: WIDTH];
    assign out_aux    = entry_out[FLAGS_W +: WIDTH];
    assign out_flags  = entry_out[FLAGS_W-1:0];

    // chain_clr overrides a same-cycle load so a new chain always starts from zero.
    always_comb begin
        carry_fb_d  = carry_fb_q;
        borrow_fb_d = borrow_fb_q;
        if (chain_clr) begin
            carry_fb_d  = 1'b0;
            borrow_fb_d = 1'b0;
        end else if (push) begin
            if (sel_arith == ARITH_ADD) begin
                carry_fb_d = carryout;
            end
            if (sel_arith == ARITH_SUB) begin
                borrow_fb_d = borrowout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_fb_q  <= 1'b0;
            borrow_fb_q <= 1'b0;
        end else begin
            carry_fb_q  <= carry_fb_d;
            borrow_fb_q <= borrow_fb_d;
        end
    end

    assign carry_fb  = carry_fb_q;
    assign borrow_fb = borrow_fb_q;

`ifdef ARITH_STICKY_FLAGS_EN
    logic [1:0] sticky_q, sticky_d;

    always_comb begin
        sticky_d = sticky_q;
        if (chain_clr) begin
            sticky_d = 2'b00;
        end else if (push) begin
            sticky_d = sticky_q | {flags_in[FLG_D], flags_in[FLG_V]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 2'b00;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_flags = sticky_q;
`else
    assign sticky_flags = 2'b00;
`endif

endmodule
